// File: rtl/sv32_page_walker_if.sv
// rtl/sv32_page_walker_if.sv - request, PTE-read and response bundle of the Sv32 walker
interface sv32_page_walker_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_va;
  logic        req_is_inst;
  logic        req_is_load;
  logic        req_is_store;

  logic        DMEM_en;
  logic [31:0] DMEM_addr;
  logic        DMEM_return;
  logic [31:0] DMEM_out;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_pa;
  logic        resp_fault;
  logic        resp_fault_inst;
  logic        resp_fault_load;
  logic        resp_fault_store;
  logic [31:0] resp_fault_va;

  // slave is the walker's view, master is the requester/memory side
  modport slave (
    input  req_valid, req_va, req_is_inst, req_is_load, req_is_store,
    output req_ready,
    output DMEM_en, DMEM_addr,
    input  DMEM_return, DMEM_out,
    output resp_valid, resp_pa, resp_fault, resp_fault_inst, resp_fault_load,
    output resp_fault_store, resp_fault_va,
    input  resp_ready
  );

  modport master (
    output req_valid, req_va, req_is_inst, req_is_load, req_is_store,
    input  req_ready,
    input  DMEM_en, DMEM_addr,
    output DMEM_return, DMEM_out,
    input  resp_valid, resp_pa, resp_fault, resp_fault_inst, resp_fault_load,
    input  resp_fault_store, resp_fault_va,
    output resp_ready
  );
endinterface

// File: rtl/sv32_page_walker.sv
// rtl/sv32_page_walker.sv - sequential Sv32 two-level page-table walker with permission checks
module sv32_page_walker (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [1:0]        priv,
  input  logic              sstatus_sum,
  input  logic [31:0]       csr_satp,
  sv32_page_walker_if.slave bus
);
  localparam logic [1:0] PRIV_USER  = 2'b00;
  localparam logic [1:0] PRIV_SUPER = 2'b01;

  typedef enum logic [1:0] {S_IDLE, S_L1, S_L0, S_RESP} state_t;
  state_t state, state_nxt;

  logic [31:0] va_q;
  logic        is_inst_q, is_load_q, is_store_q;
  logic [1:0]  priv_q;
  logic        sum_q;
  logic [19:0] root_q;
  logic [19:0] base_q;
  logic [31:0] pa_q;
  logic [31:0] fault_va_q;
  logic        fault_q;

  logic        accept, dmem_hit;
  logic [31:0] pte;
  logic        pte_v, pte_r, pte_w, pte_x, pte_u, pte_d;
  logic        pte_bad, pte_leaf, perm_fault;
  logic        l1_done, l1_fault, l0_fault;
  logic        unused_bits;

  assign pte    = bus.DMEM_out;
  assign pte_v  = pte[0];
  assign pte_r  = pte[1];
  assign pte_w  = pte[2];
  assign pte_x  = pte[3];
  assign pte_u  = pte[4];
  assign pte_d  = pte[7];

  assign unused_bits = ^{csr_satp[30:20], pte[31:30], pte[9:8], pte[6:5]};

  assign accept   = bus.req_valid && bus.req_ready;
  assign dmem_hit = bus.DMEM_en && bus.DMEM_return;

  assign pte_bad  = !pte_v || (!pte_r && pte_w);
  assign pte_leaf = pte_r || pte_x;

  // Machine mode matches neither privilege compare, so U checks drop out naturally
  assign perm_fault = (!pte_u && priv_q == PRIV_USER)
                   || (pte_u && priv_q == PRIV_SUPER && !sum_q)
                   || (is_inst_q && !pte_x)
                   || (is_load_q && !pte_r)
                   || (is_store_q && (!pte_w || !pte_d));

  assign l1_done  = pte_bad || pte_leaf;
  assign l1_fault = pte_bad || (pte_leaf && (perm_fault || pte[19:10] != 10'd0));
  assign l0_fault = pte_bad || !pte_leaf || perm_fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = csr_satp[31] ? S_L1 : S_RESP;
      S_L1:   if (dmem_hit) state_nxt = l1_done ? S_RESP : S_L0;
      S_L0:   if (dmem_hit) state_nxt = S_RESP;
      S_RESP: if (bus.resp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      va_q       <= '0;
      is_inst_q  <= 1'b0;
      is_load_q  <= 1'b0;
      is_store_q <= 1'b0;
      priv_q     <= '0;
      sum_q      <= 1'b0;
      root_q     <= '0;
      base_q     <= '0;
      pa_q       <= '0;
      fault_q    <= 1'b0;
      fault_va_q <= '0;
    end else if (accept) begin
      va_q       <= bus.req_va;
      is_inst_q  <= bus.req_is_inst;
      is_load_q  <= bus.req_is_load;
      is_store_q <= bus.req_is_store;
      priv_q     <= priv;
      sum_q      <= sstatus_sum;
      root_q     <= csr_satp[19:0];
      pa_q       <= csr_satp[31] ? 32'd0 : bus.req_va;
      fault_q    <= 1'b0;
      fault_va_q <= '0;
    end else if (dmem_hit && state == S_L1) begin
      if (l1_done) begin
        fault_q    <= l1_fault;
        fault_va_q <= l1_fault ? va_q : 32'd0;
        pa_q       <= l1_fault ? 32'd0 : {pte[29:20], va_q[21:0]};
      end else begin
        base_q     <= pte[29:10];
      end
    end else if (dmem_hit && state == S_L0) begin
      fault_q    <= l0_fault;
      fault_va_q <= l0_fault ? va_q : 32'd0;
      pa_q       <= l0_fault ? 32'd0 : {pte[29:10], va_q[11:0]};
    end
  end

  always_comb begin
    bus.req_ready  = 1'b0;
    bus.DMEM_en    = 1'b0;
    bus.DMEM_addr  = 32'd0;
    bus.resp_valid = 1'b0;
    case (state)
      S_IDLE: bus.req_ready = !flush;
      S_L1: begin
        bus.DMEM_en   = !flush;
        bus.DMEM_addr = {root_q, 12'd0} + {20'd0, va_q[31:22], 2'b00};
      end
      S_L0: begin
        bus.DMEM_en   = !flush;
        bus.DMEM_addr = {base_q, 12'd0} + {20'd0, va_q[21:12], 2'b00};
      end
      S_RESP: bus.resp_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.resp_pa          = pa_q;
  assign bus.resp_fault       = fault_q;
  assign bus.resp_fault_inst  = fault_q && is_inst_q;
  assign bus.resp_fault_load  = fault_q && is_load_q;
  assign bus.resp_fault_store = fault_q && is_store_q;
  assign bus.resp_fault_va    = fault_va_q;
endmodule

// File: tb/tb_sv32_page_walker.sv
// tb/tb_sv32_page_walker.sv - directed self-checking bench for sv32_page_walker
module tb_sv32_page_walker;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [1:0]  priv;
  logic        sstatus_sum;
  logic [31:0] csr_satp;

  sv32_page_walker_if bus();

  sv32_page_walker dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .priv        (priv),
    .sstatus_sum (sstatus_sum),
    .csr_satp    (csr_satp),
    .bus         (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // PTE memory model with a programmable response delay per read
  logic [31:0] mem [logic [31:0]];
  int          dmem_delay = 0;
  int          wait_cnt   = 0;
  int          rd_count   = 0;
  int          stab_err   = 0;
  logic        in_read    = 1'b0;
  logic [31:0] held_addr  = '0;
  logic [31:0] rd_log [$];

  always @(negedge clk) begin
    if (!rst_n || !bus.DMEM_en) begin
      bus.DMEM_return = 1'b0;
      bus.DMEM_out    = 32'd0;
      wait_cnt        = 0;
      in_read         = 1'b0;
    end else begin
      if (in_read && bus.DMEM_addr != held_addr) stab_err++;
      in_read   = 1'b1;
      held_addr = bus.DMEM_addr;
      if (wait_cnt == dmem_delay) begin
        bus.DMEM_return = 1'b1;
        bus.DMEM_out    = mem.exists(bus.DMEM_addr) ? mem[bus.DMEM_addr] : 32'd0;
        rd_log.push_back(bus.DMEM_addr);
        rd_count++;
        wait_cnt = 0;
        in_read  = 1'b0;
      end else begin
        bus.DMEM_return = 1'b0;
        wait_cnt++;
      end
    end
  end

  localparam int K_INST = 0, K_LOAD = 1, K_STORE = 2;
  localparam logic [1:0] P_USER = 2'b00, P_SUPER = 2'b01;

  task automatic start_req(input logic [31:0] va, input int kind, input logic [1:0] pv,
                           input logic sum, input logic [31:0] satp);
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_va       = va;
    bus.req_is_inst  = (kind == K_INST);
    bus.req_is_load  = (kind == K_LOAD);
    bus.req_is_store = (kind == K_STORE);
    priv             = pv;
    sstatus_sum      = sum;
    csr_satp         = satp;
    rd_log.delete();
    rd_count = 0;
    @(posedge clk);
    #1;
    // scramble the request inputs to prove the walk uses latched copies
    bus.req_valid    = 1'b0;
    bus.req_va       = 32'hdead_beef;
    bus.req_is_inst  = 1'b0;
    bus.req_is_load  = 1'b0;
    bus.req_is_store = 1'b0;
    priv             = 2'b11;
    sstatus_sum      = ~sum;
    csr_satp         = 32'h0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      lat++;
      if (bus.resp_valid) return;
    end
    check("resp_timeout", 32'd0, 32'd1);
  endtask

  task automatic ack;
    @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic walk(input string tag, input logic [31:0] va, input int kind,
                      input logic [1:0] pv, input logic sum, input logic [31:0] satp,
                      input int exp_lat, input logic [31:0] exp_pa,
                      input logic [2:0] exp_fault);
    int lat;
    start_req(va, kind, pv, sum, satp);
    wait_resp(lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_pa"}, bus.resp_pa, exp_pa);
    check({tag, "_fault"}, {bus.resp_fault_store, bus.resp_fault_load, bus.resp_fault_inst},
          {29'd0, exp_fault});
    check({tag, "_fault_any"}, bus.resp_fault, (exp_fault != 3'b000));
    check({tag, "_fault_va"}, bus.resp_fault_va, (exp_fault != 3'b000) ? va : 32'd0);
    ack();
  endtask

  localparam logic [31:0] SATP = 32'h8000_0080;

  initial begin
    int lat;
    logic seen;
    rst_n = 1'b0; flush = 1'b0; priv = P_SUPER; sstatus_sum = 1'b0; csr_satp = 32'd0;
    bus.req_valid = 1'b0; bus.req_va = 32'd0; bus.req_is_inst = 1'b0;
    bus.req_is_load = 1'b0; bus.req_is_store = 1'b0; bus.resp_ready = 1'b0;
    #1;
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_dmem_en", bus.DMEM_en, 0);
    check("rst_dmem_addr", bus.DMEM_addr, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_pa", bus.resp_pa, 0);
    check("rst_fault", bus.resp_fault, 0);
    check("rst_fault_va", bus.resp_fault_va, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // bare translation
    walk("bare", 32'h1234_5678, K_LOAD, P_SUPER, 0, 32'h0, 1, 32'h1234_5678, 3'b000);
    check("bare_reads", rd_count, 0);

    // 4 KiB page walk
    mem[32'h0008_0004] = 32'h0002_0401;
    mem[32'h0008_1004] = 32'h048D_1483;
    walk("k4", 32'h0040_1234, K_LOAD, P_SUPER, 0, SATP, 3, 32'h1234_5234, 3'b000);
    check("k4_reads", rd_count, 2);
    check("k4_addr1", rd_log[0], 32'h0008_0004);
    check("k4_addr0", rd_log[1], 32'h0008_1004);

    // megapage fetch, then misaligned megapage
    mem[32'h0008_0008] = 32'h0010_00CF;
    walk("mega", 32'h0080_0ABC, K_INST, P_SUPER, 0, SATP, 2, 32'h0040_0ABC, 3'b000);
    check("mega_addr", rd_log[0], 32'h0008_0008);
    mem[32'h0008_0008] = 32'h0010_04CF;
    walk("mis", 32'h0080_0ABC, K_INST, P_SUPER, 0, SATP, 2, 32'h0, 3'b001);

    // store to clean page, U page vs SUM, user on supervisor page, machine on U page
    mem[32'h0008_0008] = 32'h0010_0047;
    walk("dirty", 32'h0080_0ABC, K_STORE, P_SUPER, 0, SATP, 2, 32'h0, 3'b100);
    mem[32'h0008_0008] = 32'h0010_0053;
    walk("sum0", 32'h0080_0ABC, K_LOAD, P_SUPER, 0, SATP, 2, 32'h0, 3'b010);
    walk("sum1", 32'h0080_0ABC, K_LOAD, P_SUPER, 1, SATP, 2, 32'h0040_0ABC, 3'b000);
    walk("mach", 32'h0080_0ABC, K_LOAD, 2'b11, 0, SATP, 2, 32'h0040_0ABC, 3'b000);
    mem[32'h0008_0008] = 32'h0010_00CF;
    walk("user", 32'h0080_0ABC, K_LOAD, P_USER, 0, SATP, 2, 32'h0, 3'b010);

    // invalid L1, and non-leaf pointer at L0
    mem[32'h0008_000C] = 32'h0000_0000;
    walk("inv1", 32'h00C0_0000, K_LOAD, P_SUPER, 0, SATP, 2, 32'h0, 3'b010);
    mem[32'h0008_0010] = 32'h0002_0401;
    mem[32'h0008_1000] = 32'h0002_0401;
    walk("ptr0", 32'h0100_0000, K_STORE, P_SUPER, 0, SATP, 3, 32'h0, 3'b100);

    // delayed DMEM return on a megapage
    dmem_delay = 4;
    stab_err   = 0;
    walk("slow", 32'h0080_0ABC, K_INST, P_SUPER, 0, SATP, 6, 32'h0040_0ABC, 3'b000);
    check("slow_addr_stable", stab_err, 0);

    // flush while waiting for the L0 PTE
    dmem_delay = 20;
    start_req(32'h0040_1234, K_LOAD, P_SUPER, 0, SATP);
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      seen = bus.DMEM_en && bus.DMEM_addr == 32'h0008_1004;
    end
    check("flush_reached_l0", seen, 1);
    flush = 1'b1;
    #1;
    check("flush_en_gated", bus.DMEM_en, 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_en", bus.DMEM_en, 0);
    check("flush_req_ready", bus.req_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      seen = seen | bus.resp_valid | bus.DMEM_en;
    end
    check("flush_quiet", seen, 0);
    dmem_delay = 0;

    // request offered together with flush is refused
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_va = 32'h0000_4000; bus.req_is_load = 1'b1;
    csr_satp = 32'h0; flush = 1'b1;
    #1;
    check("flushreq_ready", bus.req_ready, 0);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0; bus.req_is_load = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flushreq_no_resp", bus.resp_valid, 0);

    // back-pressure on the response
    start_req(32'h0000_5678, K_LOAD, P_SUPER, 0, 32'h0);
    wait_resp(lat);
    check("bp_lat", lat, 1);
    bus.req_valid = 1'b1; bus.req_va = 32'h0000_9999; bus.req_is_load = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid", bus.resp_valid, 1);
      check("bp_pa", bus.resp_pa, 32'h0000_5678);
      check("bp_req_ready", bus.req_ready, 0);
    end
    bus.req_valid = 1'b0; bus.req_is_load = 1'b0;
    ack();
    @(negedge clk);
    check("bp_released", bus.resp_valid, 0);

    // asynchronous reset mid-walk
    dmem_delay = 20;
    start_req(32'h0040_1234, K_LOAD, P_SUPER, 0, SATP);
    repeat (3) @(negedge clk);
    check("arst_walking", bus.DMEM_en, 1);
    rst_n = 1'b0;
    #1;
    check("arst_dmem_en", bus.DMEM_en, 0);
    check("arst_dmem_addr", bus.DMEM_addr, 0);
    check("arst_req_ready", bus.req_ready, 1);
    check("arst_resp_valid", bus.resp_valid, 0);
    check("arst_pa", bus.resp_pa, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dmem_delay = 0;

    // walker is usable again after reset
    walk("post", 32'h0040_1234, K_LOAD, P_SUPER, 0, SATP, 3, 32'h1234_5234, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
